tw_seq_gen: RTL and testbench

Parametrised twiddle-factor sequencer for the radix-2 FFT datapath. It replaces fixed per-stage twiddle ROMs with one quarter-wave cosine table and an address sequencer. On a start pulse it streams the N/2 twiddles for the requested stage, in butterfly order, over a valid/ready interface. It sits between the FFT stage controller and the butterfly multiplier and supports both forward and inverse (conjugate) modes.

---
 rtl/tw_pkg.sv | 22 ++
 rtl/tw_qrom.sv | 27 ++
 rtl/tw_seq_gen.sv | 157 +++++++++++++++
 tb/tb_tw_seq_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tw_pkg.sv
// Shared definitions for the twiddle sequencer: FSM state encoding, the
// Q2.(W-2) unit value and the elaboration-time quarter-wave cosine generator.
package tw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int  TW_DATA_W = 10;
    localparam int  ONE       = 1 << (TW_DATA_W - 2);
    localparam real TW_PI     = 3.14159265358979323846;

    // Only called for q in 0..n/4, where the cosine is non-negative, so +0.5 then truncate rounds.
    function automatic int cos_q(input int q, input int n, input int w);
        real scaled;
        scaled = $cos(2.0 * TW_PI * real'(q) / real'(n)) * real'(1 << (w - 2));
        return $rtoi(scaled + 0.5);
    endfunction

endpackage

// File: rtl/tw_qrom.sv
// Quarter-wave cosine table (N/4+1 entries, Q2.(DATA_W-2)) with two
// independent combinational read ports.
module tw_qrom
    import tw_pkg::*;
#(
    parameter  int N_FFT  = 512,
    parameter  int DATA_W = TW_DATA_W,
    localparam int ADDR_W = $clog2(N_FFT) - 1
) (
    input  logic        [ADDR_W-1:0] addr_a,
    input  logic        [ADDR_W-1:0] addr_b,
    output logic signed [DATA_W-1:0] data_a,
    output logic signed [DATA_W-1:0] data_b
);

    localparam int DEPTH = N_FFT / 4 + 1;

    logic signed [DATA_W-1:0] rom [DEPTH];

    for (genvar q = 0; q < DEPTH; q++) begin : g_rom
        assign rom[q] = DATA_W'(cos_q(q, N_FFT, DATA_W));
    end

    assign data_a = rom[addr_a];
    assign data_b = rom[addr_b];

endmodule

// File: rtl/tw_seq_gen.sv
// Radix-2 FFT twiddle sequencer: streams the N/2 twiddles of one stage from a
// quarter-wave cosine table through a two-stage stallable pipeline.
module tw_seq_gen
    import tw_pkg::*;
#(
    parameter  int N_FFT   = 512,
    parameter  int DATA_W  = TW_DATA_W,
    localparam int LOG2N   = $clog2(N_FFT),
    localparam int STAGE_W = $clog2(LOG2N),
    localparam int K_W     = LOG2N - 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic        [STAGE_W-1:0] stage,
    input  logic                      inv,
    output logic                      busy,
    output logic                      tw_valid,
    input  logic                      tw_ready,
    output logic signed [DATA_W-1:0]  tw_re,
    output logic signed [DATA_W-1:0]  tw_im,
    output logic        [K_W-1:0]     tw_k,
    output logic                      tw_last,
    output logic                      done
);

    localparam int                 HALF      = N_FFT / 2;
    localparam int                 QTR       = N_FFT / 4;
    localparam logic [K_W-1:0]     LAST_IDX  = K_W'(HALF - 1);
    localparam logic [K_W-1:0]     QTR_K     = K_W'(QTR);
    localparam logic [STAGE_W-1:0] MAX_STAGE = STAGE_W'(LOG2N - 1);

    function automatic logic signed [DATA_W-1:0] apply_sign(
        input logic signed [DATA_W-1:0] val,
        input logic                     neg
    );
        return neg ? -val : val;
    endfunction

    state_t             state, state_nxt;
    logic [STAGE_W-1:0] stage_q;
    logic               inv_q;
    logic [K_W-1:0]     idx;
    logic               pipe_en, accept, issue, last_issue, last_hs;

    logic [K_W-1:0]     mask, k_issue, addr_re, addr_im;
    logic               neg_re, neg_im;

    logic               vld_p1, last_p1, neg_re_p1, neg_im_p1;
    logic [K_W-1:0]     k_p1, addr_re_p1, addr_im_p1;
    logic signed [DATA_W-1:0] cos_re, cos_im;

    assign pipe_en    = ~tw_valid | tw_ready;
    assign accept     = (state == IDLE) & start;
    assign issue      = (state == RUN) & pipe_en;
    assign last_issue = issue & (idx == LAST_IDX);
    assign last_hs    = tw_valid & tw_ready & tw_last;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)      state_nxt = RUN;
            RUN:     if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (last_hs)    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_q <= '0;
            inv_q   <= 1'b0;
            idx     <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == DRAIN) & last_hs;
            if (accept) begin
                stage_q <= (stage > MAX_STAGE) ? MAX_STAGE : stage;
                inv_q   <= inv;
                idx     <= '0;
            end else if (issue) begin
                idx <= idx + K_W'(1);
            end
        end
    end

    // k = (i mod (N >> (s+1))) << s, folded onto the first quarter wave.
    always_comb begin
        mask    = K_W'((HALF >> stage_q) - 1);
        k_issue = (idx & mask) << stage_q;
        neg_im  = ~inv_q;
        if (k_issue <= QTR_K) begin
            addr_re = k_issue;
            addr_im = QTR_K - k_issue;
            neg_re  = 1'b0;
        end else begin
            addr_re = K_W'(HALF - int'(k_issue));
            addr_im = K_W'(int'(k_issue) - QTR);
            neg_re  = 1'b1;
        end
    end

    // P1: exponent, table addresses and signs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            k_p1       <= '0;
            addr_re_p1 <= '0;
            addr_im_p1 <= '0;
            neg_re_p1  <= 1'b0;
            neg_im_p1  <= 1'b0;
        end else if (pipe_en) begin
            vld_p1     <= issue;
            last_p1    <= last_issue;
            k_p1       <= k_issue;
            addr_re_p1 <= addr_re;
            addr_im_p1 <= addr_im;
            neg_re_p1  <= neg_re;
            neg_im_p1  <= neg_im;
        end
    end

    tw_qrom #(
        .N_FFT  (N_FFT),
        .DATA_W (DATA_W)
    ) u_qrom (
        .addr_a (addr_re_p1),
        .addr_b (addr_im_p1),
        .data_a (cos_re),
        .data_b (cos_im)
    );

    // P2: signed table data into the output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tw_valid <= 1'b0;
            tw_last  <= 1'b0;
            tw_k     <= '0;
            tw_re    <= '0;
            tw_im    <= '0;
        end else if (pipe_en) begin
            tw_valid <= vld_p1;
            tw_last  <= last_p1;
            tw_k     <= k_p1;
            tw_re    <= apply_sign(cos_re, neg_re_p1);
            tw_im    <= apply_sign(cos_im, neg_im_p1);
        end
    end

endmodule

// File: tb/tb_tw_seq_gen.sv
// Bench for tw_seq_gen: an N=8 vector table with hand-written corner sequences,
// and N=512 runs under random back-pressure checked against a sin/cos model.
module tb_tw_seq_gen;
    import tw_pkg::*;

    localparam int DW = 10;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic                 start8, inv8, busy8, valid8, ready8, last8, done8;
    logic [1:0]           stage8, k8;
    logic signed [DW-1:0] re8, im8;

    logic                 start5, inv5, busy5, valid5, ready5, last5, done5;
    logic [3:0]           stage5;
    logic [7:0]           k5;
    logic signed [DW-1:0] re5, im5;

    tw_seq_gen #(.N_FFT(8), .DATA_W(DW)) dut8 (
        .clk(clk), .rstn(rstn), .start(start8), .stage(stage8), .inv(inv8),
        .busy(busy8), .tw_valid(valid8), .tw_ready(ready8), .tw_re(re8),
        .tw_im(im8), .tw_k(k8), .tw_last(last8), .done(done8)
    );

    tw_seq_gen #(.N_FFT(512), .DATA_W(DW)) dut512 (
        .clk(clk), .rstn(rstn), .start(start5), .stage(stage5), .inv(inv5),
        .busy(busy5), .tw_valid(valid5), .tw_ready(ready5), .tw_re(re5),
        .tw_im(im5), .tw_k(k5), .tw_last(last5), .done(done5)
    );

    typedef struct {
        int stage;
        int inv;
        int k;
        int re;
        int im;
    } vec_t;

    vec_t       tbl [20];
    logic [5:0] pat = 6'b101001;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    // W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N); the inverse transform uses the conjugate.
    function automatic void ref_tw(input int n, input int k, input int iv,
                                   output int re, output int im);
        real a;
        a  = 2.0 * 3.14159265358979323846 * real'(k) / real'(n);
        re = rnd($cos(a) * real'(ONE));
        im = rnd(-$sin(a) * real'(ONE));
        if (iv != 0) im = -im;
    endfunction

    function automatic int ref_k(input int n, input int s, input int i);
        int lg;
        int se;
        lg = $clog2(n);
        se = (s > lg - 1) ? lg - 1 : s;
        return (i % (n >> (se + 1))) * (1 << se);
    endfunction

    task automatic expect8(input int row0, input int exp_lat);
        int edges = 0;
        while (!valid8 && edges < 8) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("first_valid_latency8", edges, exp_lat);
        for (int j = 0; j < 4; j++) begin
            chk("valid8", int'(valid8), 1);
            chk("k8", int'(k8), tbl[row0 + j].k);
            chk("re8", int'(re8), tbl[row0 + j].re);
            chk("im8", int'(im8), tbl[row0 + j].im);
            chk("last8", int'(last8), (j == 3) ? 1 : 0);
            @(posedge clk); #1;
        end
        chk("done8_after_last", int'(done8), 1);
        chk("busy8_in_done", int'(busy8), 0);
    endtask

    task automatic full8(input int row0);
        start8 = 1'b1;
        stage8 = 2'(tbl[row0].stage);
        inv8   = (tbl[row0].inv != 0);
        ready8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("busy8_after_start", int'(busy8), 1);
        expect8(row0, 2);
        @(posedge clk); #1;
        chk("done8_single_cycle", int'(done8), 0);
    endtask

    task automatic run512(input int stg, input int iv, input bit fixed_pat);
        int idx = 0;
        int vcyc = 0;
        int cyc = 0;
        int ek, ere, eim;
        start5 = 1'b1;
        stage5 = 4'(stg);
        inv5   = (iv != 0);
        ready5 = 1'b1;
        @(posedge clk); #1;
        start5 = 1'b0;
        while (idx < 256 && cyc < 3000) begin
            if (fixed_pat && vcyc < 6) ready5 = pat[vcyc];
            else                       ready5 = 1'($urandom_range(0, 1));
            if (idx > 0) chk("valid512_steady", int'(valid5), 1);
            if (valid5) begin
                ek = ref_k(512, stg, idx);
                ref_tw(512, ek, iv, ere, eim);
                chk("k512", int'(k5), ek);
                chk("re512", int'(re5), ere);
                chk("im512", int'(im5), eim);
                chk("last512", int'(last5), (idx == 255) ? 1 : 0);
                if (ready5) idx++;
                vcyc++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("stream512_len", idx, 256);
        chk("done512_after_last", int'(done5), 1);
        chk("busy512_in_done", int'(busy5), 0);
        ready5 = 1'b1;
        @(posedge clk); #1;
        chk("done512_single_cycle", int'(done5), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn   = 1'b0;
        start8 = 1'b0; stage8 = '0; inv8 = 1'b0; ready8 = 1'b0;
        start5 = 1'b0; stage5 = '0; inv5 = 1'b0; ready5 = 1'b0;

        tbl[0]  = '{0, 0, 0, ONE, 0};   tbl[1]  = '{0, 0, 1, 181, -181};
        tbl[2]  = '{0, 0, 2, 0, -ONE};  tbl[3]  = '{0, 0, 3, -181, -181};
        tbl[4]  = '{1, 0, 0, ONE, 0};   tbl[5]  = '{1, 0, 2, 0, -ONE};
        tbl[6]  = '{1, 0, 0, ONE, 0};   tbl[7]  = '{1, 0, 2, 0, -ONE};
        tbl[8]  = '{2, 0, 0, ONE, 0};   tbl[9]  = '{2, 0, 0, ONE, 0};
        tbl[10] = '{2, 0, 0, ONE, 0};   tbl[11] = '{2, 0, 0, ONE, 0};
        tbl[12] = '{0, 1, 0, ONE, 0};   tbl[13] = '{0, 1, 1, 181, 181};
        tbl[14] = '{0, 1, 2, 0, ONE};   tbl[15] = '{0, 1, 3, -181, 181};
        tbl[16] = '{3, 0, 0, ONE, 0};   tbl[17] = '{3, 0, 0, ONE, 0};
        tbl[18] = '{3, 0, 0, ONE, 0};   tbl[19] = '{3, 0, 0, ONE, 0};

        #12;
        chk("rst_busy8", int'(busy8), 0);
        chk("rst_valid8", int'(valid8), 0);
        chk("rst_last8", int'(last8), 0);
        chk("rst_done8", int'(done8), 0);
        chk("rst_re8", int'(re8), 0);
        chk("rst_im8", int'(im8), 0);
        chk("rst_k8", int'(k8), 0);
        chk("rst_valid512", int'(valid5), 0);
        chk("rst_busy512", int'(busy5), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < 5; r++) full8(r * 4);

        // A second start while busy must not disturb the running stage.
        start8 = 1'b1; stage8 = 2'd0; inv8 = 1'b0; ready8 = 1'b1;
        @(posedge clk); #1;
        stage8 = 2'd1; inv8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("busy8_ignored_start", int'(busy8), 1);
        expect8(0, 1);
        // A start presented in the done cycle is accepted.
        start8 = 1'b1; stage8 = 2'd1; inv8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("busy8_restart_in_done", int'(busy8), 1);
        chk("done8_restart", int'(done8), 0);
        expect8(4, 2);
        @(posedge clk); #1;
        chk("busy8_idle", int'(busy8), 0);

        // Reset mid-stream after two outputs have been taken.
        start8 = 1'b1; stage8 = 2'd0; inv8 = 1'b0; ready8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("k8_before_reset", int'(k8), 2);
        rstn = 1'b0;
        #1;
        chk("midrst_valid8", int'(valid8), 0);
        chk("midrst_busy8", int'(busy8), 0);
        chk("midrst_last8", int'(last8), 0);
        chk("midrst_re8", int'(re8), 0);
        chk("midrst_im8", int'(im8), 0);
        chk("midrst_k8", int'(k8), 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("midrst_no_done8", int'(done8), 0);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        full8(0);

        run512(0, 0, 1'b1);
        run512(0, 1, 1'b0);
        run512(3, 0, 1'b0);
        run512(12, 1, 1'b0);
        for (int t = 0; t < 2; t++) run512(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
